axil_regfile: RTL and testbench
===============================

Name: axil_regfile

Overview:
Parametrised AXI4-Lite slave register file. It generalises the fixed four-register slave to NUM_REGS words, with per-byte write strobes, a per-register read-only mask and independent AW/W acceptance. Out-of-range and read-only accesses return SLVERR. It sits behind the AXI-Lite interconnect as the control/status block of a pipeline stage, and exposes the register contents and write pulses to the datapath.

Parameters:
ADDR_WIDTH, 8, AXI-Lite address width in bits
DATA_WIDTH, 32, data width in bits; must be 32 or 64
NUM_REGS, 16, number of word registers; 1..2**(ADDR_WIDTH-ADDRLSB)
RO_MASK, '0 (NUM_REGS bits), bit i set = register i is read-only and sourced from ro_i

Ports:
clk_i  input  1  the single clock
rst_i  input  1  reset, synchronous, active-high
axil  interface  AXI_LITE slave  aw/w/b/ar/r channels, ADDR_WIDTH/DATA_WIDTH
reg_o  output  NUM_REGS*DATA_WIDTH  RW register contents; word i = bits [i*DATA_WIDTH +: DATA_WIDTH]
ro_i  input  NUM_REGS*DATA_WIDTH  status values returned for RO registers; same packing as reg_o
wr_pulse_o  output  NUM_REGS  one-cycle pulse on a committed write to register i

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Decode:
  - ADDRLSB = log2(DATA_WIDTH/8).
  - idx = addr[ADDR_WIDTH-1:ADDRLSB]; byte-offset bits are ignored.
  - idx >= NUM_REGS is out of range.
- Reset values, applied while rst_i is high:
  - All RW registers 0.
  - bvalid, rvalid, wr_pulse_o = 0; rdata, bresp, rresp = 0.
  - AW and W holding slots empty.
  - awready, wready, arready forced to 0.
- Write acceptance:
  - AW and W each have a one-entry holding slot.
  - awready = !aw_full; wready = !w_full.
  - The two channels are accepted in either order, or in the same cycle.
- Write commit:
  - Occurs at the first edge where aw_full && w_full && (!bvalid || bready).
  - Both slots are freed at that edge.
  - Latency: handshake of the later channel at edge t -> commit at edge t+1 -> bvalid high in cycle t+2.
  - Sustained throughput is one write per 2 cycles.
- Commit action:
  - In range and RW: byte k is updated iff wstrb[k]; bresp = OKAY (2'b00); wr_pulse_o[idx] = 1 for exactly one cycle.
  - Out of range, or RO: no state change, no pulse, bresp = SLVERR (2'b10).
  - wstrb = 0 on an RW register: OKAY, no data change, pulse still asserted.
- B channel:
  - bvalid is set on commit and cleared on a bvalid && bready handshake.
  - If commit and handshake fall on the same edge, bvalid stays 1 with the new bresp.
  - bresp is stable while bvalid && !bready.
- Read path:
  - arready = !rvalid || rready, so reads are 1 per cycle under continuous rready.
  - AR handshake at edge t -> rdata/rresp registered -> rvalid high in cycle t+1.
  - Data source: RW register -> reg_o word; RO register -> ro_i word sampled at the AR edge; out of range -> rdata 0 with SLVERR.
  - rdata and rresp are held stable while rvalid && !rready.
- Simultaneous read and write: a commit and an AR handshake to the same register on the same edge return the pre-write value.
- reg_o words for RO indices are driven to 0.
- Reset mid-operation: partially accepted transactions are dropped and no response is issued for them.
- No AXI protocol violations under any valid/ready pattern:
  - valid outputs never depend combinationally on ready inputs;
  - valid outputs never drop without a handshake.

Decomposition:
- Package axil_pkg:
  - resp_t (2-bit) with RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10;
  - function addr_lsb(DATA_WIDTH);
  - function apply_wstrb(old, new, strb).
- Sub-module axil_hold_slot:
  - parametrised-width one-entry valid/ready buffer with full flag, load and clear;
  - instantiated once for AW (addr) and once for W (data+strb).

Test Plan:
1. Write 0xDEADBEEF to 0x04 with wstrb 0xF, then read 0x04 -> bresp OKAY; wr_pulse_o[1] high for one cycle; rdata 0xDEADBEEF, rresp OKAY; reg_o word1 = 0xDEADBEEF.
2. Reg2 = 0x11223344; write 0xAABBCCDD with wstrb 4'b0101 -> reg2 = 0x11BB33DD; read back confirms.
3. W handshake 3 cycles before AW -> wready 0 after W is accepted, awready remains 1; bvalid first rises 2 cycles after the AW handshake; data lands at the AW address.
4. RO_MASK = 16'h8000, ro_i word15 = 0xCAFE0001:
   - write 0x3C -> SLVERR, no pulse, no state change;
   - read 0x3C -> 0xCAFE0001, OKAY;
   - write or read at 0x40 -> SLVERR, read rdata 0.
5. Backpressure, bready low for 5 cycles with a second write offered -> bvalid and bresp stable; second write held until bready; awready/wready 0 once slots are full. Read with rready low -> rdata stable and arready 0 until rready.
6. rst_i pulsed for 1 cycle after AW is accepted but before W -> after release: bvalid 0, slots empty, all readies 1, reg_o all 0, no B response for the dropped write.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared types and helpers for the AXI4-Lite register file.
//   resp_t       : AXI response codes used on the B and R channels
//   addr_lsb()   : number of byte-offset address bits for a data width
//   apply_wstrb(): byte-wise merge of new write data into an old word
package axil_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    function automatic int addr_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    // Operates on the widest supported word (64 bits); callers cast in/out.
    function automatic logic [63:0] apply_wstrb(input logic [63:0] old_word,
                                                input logic [63:0] new_word,
                                                input logic [7:0]  strb);
        logic [63:0] merged;
        merged = old_word;
        for (int k = 0; k < 8; k++) begin
            if (strb[k]) merged[k*8 +: 8] = new_word[k*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/axil_regfile_if.sv
// AXI4-Lite bus bundle (AW/W/B/AR/R) with master and slave views.
//   ADDR_WIDTH : address width of awaddr/araddr
//   DATA_WIDTH : width of wdata/rdata; wstrb is DATA_WIDTH/8 bits
interface axil_regfile_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                    awvalid;
    logic                    awready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;
    logic                    arvalid;
    logic                    arready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    rvalid;
    logic                    rready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axil_hold_slot.sv
// One-entry valid/ready holding buffer.
//   clk_i, rst_i : clock, synchronous active-high reset (empties the slot)
//   i_valid      : upstream valid; loads i_data when the slot is empty
//   o_ready      : upstream ready (slot empty and not in reset)
//   i_clear      : frees the slot (consumer took the entry)
//   o_full       : slot holds an entry
//   o_data       : held entry
module axil_hold_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_clear,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data
);
    logic             r_full;
    logic [WIDTH-1:0] r_data;
    logic             w_load;

    assign o_ready = !r_full && !rst_i;
    assign w_load  = i_valid && o_ready;
    assign o_full  = r_full;
    assign o_data  = r_data;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_full <= 1'b0;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end else if (w_load) begin
            r_full <= 1'b1;
        end
    end

    // NOTE: payload needs no reset; it is only observed while r_full is set.
    always_ff @(posedge clk_i) begin
        if (w_load) r_data <= i_data;
    end
endmodule

// File: rtl/axil_regfile.sv
// AXI4-Lite slave register file with NUM_REGS words.
//   clk_i, rst_i : clock, synchronous active-high reset
//   axil         : AXI4-Lite slave port (AW/W/B/AR/R)
//   reg_o        : packed RW register contents (RO words read as 0)
//   ro_i         : packed status words returned for read-only registers
//   wr_pulse_o   : one-cycle pulse per register on a committed write
module axil_regfile
    import axil_pkg::*;
#(
    parameter int                  ADDR_WIDTH = 8,
    parameter int                  DATA_WIDTH = 32,
    parameter int                  NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    axil_regfile_if.slave                  axil,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_o,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_i,
    output logic [NUM_REGS-1:0]            wr_pulse_o
);
    localparam int ADDRLSB = addr_lsb(DATA_WIDTH);
    localparam int IDX_W   = ADDR_WIDTH - ADDRLSB;
    localparam int STRB_W  = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]   r_wr_pulse;
    logic                  r_bvalid;
    resp_t                 r_bresp;
    logic                  r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;
    resp_t                 r_rresp;

    logic                       w_aw_full, w_w_full;
    logic [IDX_W-1:0]           w_aw_idx;
    logic [STRB_W+DATA_WIDTH-1:0] w_w_entry;
    logic [DATA_WIDTH-1:0]      w_wdata;
    logic [STRB_W-1:0]          w_wstrb;
    logic                       w_commit;
    logic                       w_aw_hit, w_aw_ro, w_wr_ok;
    logic [IDX_W-1:0]           w_ar_idx;
    logic                       w_ar_hs, w_ar_hit;
    logic [DATA_WIDTH-1:0]      w_ar_data;
    logic                       w_unused_addr;

    // Byte-offset bits do not take part in decode.
    assign w_unused_addr = ^{axil.awaddr[ADDRLSB-1:0], axil.araddr[ADDRLSB-1:0]};

    axil_hold_slot #(.WIDTH(IDX_W)) u_aw_slot (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_valid (axil.awvalid),
        .o_ready (axil.awready),
        .i_data  (axil.awaddr[ADDR_WIDTH-1:ADDRLSB]),
        .i_clear (w_commit),
        .o_full  (w_aw_full),
        .o_data  (w_aw_idx)
    );

    axil_hold_slot #(.WIDTH(STRB_W + DATA_WIDTH)) u_w_slot (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_valid (axil.wvalid),
        .o_ready (axil.wready),
        .i_data  ({axil.wstrb, axil.wdata}),
        .i_clear (w_commit),
        .o_full  (w_w_full),
        .o_data  (w_w_entry)
    );

    assign {w_wstrb, w_wdata} = w_w_entry;

    // A new response may be produced in the same edge the old one is taken.
    assign w_commit = w_aw_full && w_w_full && (!r_bvalid || axil.bready);

    // NOTE: every always_comb output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        w_aw_hit = 1'b0;
        w_aw_ro  = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_aw_idx == IDX_W'(i)) begin
                w_aw_hit = 1'b1;
                w_aw_ro  = RO_MASK[i];
            end
        end
    end

    assign w_wr_ok  = w_aw_hit && !w_aw_ro;
    assign w_ar_idx = axil.araddr[ADDR_WIDTH-1:ADDRLSB];
    assign w_ar_hs  = axil.arvalid && axil.arready;

    // RO words are sampled from ro_i at the AR edge; RW words read the
    // register before any same-edge commit lands.
    always_comb begin
        w_ar_hit  = 1'b0;
        w_ar_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_ar_idx == IDX_W'(i)) begin
                w_ar_hit  = 1'b1;
                w_ar_data = RO_MASK[i] ? ro_i[i*DATA_WIDTH +: DATA_WIDTH] : r_regs[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
            r_wr_pulse <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
        end else begin
            r_wr_pulse <= '0;
            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
                if (w_wr_ok) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (w_aw_idx == IDX_W'(i)) begin
                            r_regs[i] <= DATA_WIDTH'(apply_wstrb(64'(r_regs[i]),
                                                                 64'(w_wdata),
                                                                 8'(w_wstrb)));
                            r_wr_pulse[i] <= 1'b1;
                        end
                    end
                end
            end else if (r_bvalid && axil.bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_ar_data;
            r_rresp  <= w_ar_hit ? RESP_OKAY : RESP_SLVERR;
        end else if (axil.rready) begin
            r_rvalid <= 1'b0;
        end
    end

    assign axil.arready = (!r_rvalid || axil.rready) && !rst_i;
    assign axil.bvalid  = r_bvalid;
    assign axil.bresp   = r_bresp;
    assign axil.rvalid  = r_rvalid;
    assign axil.rdata   = r_rdata;
    assign axil.rresp   = r_rresp;
    assign wr_pulse_o   = r_wr_pulse;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_o
        assign reg_o[g*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[g] ? '0 : r_regs[g];
    end
endmodule

// File: tb/tb_axil_regfile.sv
// Directed self-checking bench for axil_regfile (16 x 32-bit, reg 15 read-only).
module tb_axil_regfile;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NR = 16;
    localparam logic [NR-1:0] RO = 16'h8000;
    localparam int LIMIT = 20;

    logic           clk_i = 1'b0;
    logic           rst_i = 1'b1;
    logic [NR*DW-1:0] reg_o;
    logic [NR*DW-1:0] ro_i;
    logic [NR-1:0]  wr_pulse_o;

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt [NR];

    axil_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axil ();

    axil_regfile #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .RO_MASK    (RO)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .axil       (axil),
        .reg_o      (reg_o),
        .ro_i       (ro_i),
        .wr_pulse_o (wr_pulse_o)
    );

    always #5 clk_i = ~clk_i;

    // Each count grows by the number of cycles the pulse was high.
    always @(posedge clk_i) begin
        for (int i = 0; i < NR; i++) begin
            if (rst_i)              pulse_cnt[i] <= 0;
            else if (wr_pulse_o[i]) pulse_cnt[i] <= pulse_cnt[i] + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [DW-1:0] word(input int i);
        return reg_o[i*DW +: DW];
    endfunction

    function automatic int pulse_sum();
        int s = 0;
        for (int i = 0; i < NR; i++) s += pulse_cnt[i];
        return s;
    endfunction

    task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        bit aw_done = 0;
        bit w_done  = 0;
        bit aw_hs, w_hs;
        int cyc = 0;
        axil.awvalid = 1'b1; axil.awaddr = addr;
        axil.wvalid  = 1'b1; axil.wdata  = data; axil.wstrb = strb;
        axil.bready  = 1'b1;
        while (!(aw_done && w_done) && cyc < LIMIT) begin
            aw_hs = axil.awvalid && axil.awready;
            w_hs  = axil.wvalid && axil.wready;
            tick();
            cyc++;
            if (aw_hs) begin axil.awvalid = 1'b0; aw_done = 1; end
            if (w_hs)  begin axil.wvalid  = 1'b0; w_done  = 1; end
        end
        while (!axil.bvalid && cyc < LIMIT) begin
            tick();
            cyc++;
        end
        check("write_timeout", 64'(cyc >= LIMIT), 64'd0);
        axil.awvalid = 1'b0;
        axil.wvalid  = 1'b0;
        resp = axil.bresp;
        tick();
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                            output logic [1:0] resp);
        int cyc = 0;
        axil.arvalid = 1'b1; axil.araddr = addr; axil.rready = 1'b1;
        while (!axil.arready && cyc < LIMIT) begin
            tick();
            cyc++;
        end
        tick();
        axil.arvalid = 1'b0;
        while (!axil.rvalid && cyc < LIMIT) begin
            tick();
            cyc++;
        end
        check("read_timeout", 64'(cyc >= LIMIT), 64'd0);
        data = axil.rdata;
        resp = axil.rresp;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]      resp;
        logic [DW-1:0]   rdata;
        logic [NR*DW-1:0] snap;
        int              p0;
        bit              seen;

        axil.awvalid = 0; axil.awaddr = '0;
        axil.wvalid  = 0; axil.wdata  = '0; axil.wstrb = '0;
        axil.bready  = 1; axil.arvalid = 0; axil.araddr = '0; axil.rready = 1;
        ro_i = '0;
        ro_i[15*DW +: DW] = 32'hCAFE0001;

        // Reset state
        tick(); tick();
        check("rst_awready_forced", 64'(axil.awready), 64'd0);
        check("rst_arready_forced", 64'(axil.arready), 64'd0);
        rst_i = 1'b0;
        #1;
        check("rst_bvalid",  64'(axil.bvalid),  64'd0);
        check("rst_rvalid",  64'(axil.rvalid),  64'd0);
        check("rst_readies", 64'({axil.awready, axil.wready, axil.arready}), 64'h7);
        check("rst_reg_o",   64'(|reg_o), 64'd0);
        check("rst_pulse",   64'(wr_pulse_o), 64'd0);

        // 1: full-word write and read back
        p0 = pulse_cnt[1];
        axi_write(8'h04, 32'hDEADBEEF, 4'hF, resp);
        check("t1_bresp",   64'(resp), 64'd0);
        check("t1_pulse",   64'(pulse_cnt[1] - p0), 64'd1);
        check("t1_reg_o",   64'(word(1)), 64'hDEADBEEF);
        axi_read(8'h04, rdata, resp);
        check("t1_rdata",   64'(rdata), 64'hDEADBEEF);
        check("t1_rresp",   64'(resp), 64'd0);

        // 2: partial strobes
        axi_write(8'h08, 32'h11223344, 4'hF, resp);
        axi_write(8'h08, 32'hAABBCCDD, 4'b0101, resp);
        check("t2_bresp",  64'(resp), 64'd0);
        check("t2_reg_o",  64'(word(2)), 64'h11BB33DD);
        axi_read(8'h0A, rdata, resp);
        check("t2_rdata",  64'(rdata), 64'h11BB33DD);

        // 3: W accepted three cycles before AW
        axil.wvalid = 1; axil.wdata = 32'h0BADF00D; axil.wstrb = 4'hF; axil.bready = 1;
        tick();
        axil.wvalid = 0;
        check("t3_wready_full", 64'(axil.wready), 64'd0);
        check("t3_awready",     64'(axil.awready), 64'd1);
        tick(); tick();
        check("t3_no_early_b",  64'(axil.bvalid), 64'd0);
        axil.awvalid = 1; axil.awaddr = 8'h18;
        tick();
        axil.awvalid = 0;
        check("t3_bvalid_t1", 64'(axil.bvalid), 64'd0);
        tick();
        check("t3_bvalid_t2", 64'(axil.bvalid), 64'd1);
        check("t3_bresp",     64'(axil.bresp), 64'd0);
        tick();
        check("t3_reg6",      64'(word(6)), 64'h0BADF00D);

        // 4: read-only and out-of-range
        snap = reg_o;
        p0   = pulse_sum();
        axi_write(8'h3C, 32'h12121212, 4'hF, resp);
        check("t4_ro_bresp",  64'(resp), 64'd2);
        check("t4_ro_pulse",  64'(pulse_sum() - p0), 64'd0);
        check("t4_ro_state",  64'(reg_o != snap), 64'd0);
        axi_read(8'h3C, rdata, resp);
        check("t4_ro_rdata",  64'(rdata), 64'hCAFE0001);
        check("t4_ro_rresp",  64'(resp), 64'd0);
        axi_write(8'h40, 32'h34343434, 4'hF, resp);
        check("t4_oor_bresp", 64'(resp), 64'd2);
        check("t4_oor_state", 64'(reg_o != snap), 64'd0);
        axi_read(8'h40, rdata, resp);
        check("t4_oor_rdata", 64'(rdata), 64'd0);
        check("t4_oor_rresp", 64'(resp), 64'd2);

        // 5: B backpressure with a second (RO) write queued behind it
        axil.bready = 0;
        axil.awvalid = 1; axil.awaddr = 8'h0C;
        axil.wvalid  = 1; axil.wdata  = 32'h12345678; axil.wstrb = 4'hF;
        tick();
        axil.awaddr = 8'h3C; axil.wdata = 32'h55555555;
        check("t5_awready_full", 64'(axil.awready), 64'd0);
        tick();
        check("t5_bvalid_a",     64'(axil.bvalid), 64'd1);
        tick();
        axil.awvalid = 0; axil.wvalid = 0;
        for (int i = 0; i < 5; i++) begin
            check("t5_hold_bvalid", 64'(axil.bvalid), 64'd1);
            check("t5_hold_bresp",  64'(axil.bresp), 64'd0);
            check("t5_hold_ready",  64'({axil.awready, axil.wready}), 64'd0);
            tick();
        end
        check("t5_reg3", 64'(word(3)), 64'h12345678);
        axil.bready = 1;
        tick();
        check("t5_b_back2back", 64'(axil.bvalid), 64'd1);
        check("t5_bresp_b",     64'(axil.bresp), 64'd2);
        tick();
        check("t5_bvalid_done", 64'(axil.bvalid), 64'd0);

        // 5b: R backpressure with a second read queued
        axil.rready = 0; axil.arvalid = 1; axil.araddr = 8'h0C;
        tick();
        axil.araddr = 8'h04;
        for (int i = 0; i < 4; i++) begin
            check("t5_r_hold_rvalid",  64'(axil.rvalid), 64'd1);
            check("t5_r_hold_rdata",   64'(axil.rdata), 64'h12345678);
            check("t5_r_hold_arready", 64'(axil.arready), 64'd0);
            tick();
        end
        axil.rready = 1;
        #1;
        check("t5_arready_back", 64'(axil.arready), 64'd1);
        tick();
        axil.arvalid = 0;
        check("t5_r2_rdata", 64'(axil.rdata), 64'hDEADBEEF);
        tick();
        check("t5_r_done",   64'(axil.rvalid), 64'd0);

        // 7: commit and AR to the same register on the same edge
        axil.awvalid = 1; axil.awaddr = 8'h04;
        axil.wvalid  = 1; axil.wdata  = 32'h00000055; axil.wstrb = 4'hF;
        tick();
        axil.awvalid = 0; axil.wvalid = 0;
        axil.arvalid = 1; axil.araddr = 8'h04;
        tick();
        axil.arvalid = 0;
        check("t7_pre_write_rdata", 64'(axil.rdata), 64'hDEADBEEF);
        check("t7_reg1_new",        64'(word(1)), 64'h55);
        tick();

        // 6: reset between AW and W
        axil.awvalid = 1; axil.awaddr = 8'h1C;
        tick();
        axil.awvalid = 0;
        check("t6_aw_full", 64'(axil.awready), 64'd0);
        rst_i = 1;
        tick();
        check("t6_rst_awready", 64'(axil.awready), 64'd0);
        rst_i = 0;
        #1;
        check("t6_bvalid",  64'(axil.bvalid), 64'd0);
        check("t6_readies", 64'({axil.awready, axil.wready, axil.arready}), 64'h7);
        check("t6_reg_o",   64'(|reg_o), 64'd0);
        axil.wvalid = 1; axil.wdata = 32'h00000077; axil.wstrb = 4'hF;
        tick();
        axil.wvalid = 0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            seen |= axil.bvalid;
            tick();
        end
        check("t6_no_dropped_b", 64'(seen), 64'd0);
        check("t6_reg7",         64'(word(7)), 64'd0);
        axil.awvalid = 1; axil.awaddr = 8'h20;
        tick();
        axil.awvalid = 0;
        tick();
        check("t6_new_b", 64'(axil.bvalid), 64'd1);
        tick();
        check("t6_reg8",  64'(word(8)), 64'h77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
